// File: rtl/testimage_pkg.sv
// Shared definitions for the test-image frame sequencer.
//   state_t      : sequencer FSM states
//   PAT_*        : cfg_pattern codes
//   rgb_pack()   : replicate an 8-bit level onto R, G and B ({R,G,B})
package testimage_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FSYNC     = 3'd1,
        ST_GAP       = 3'd2,
        ST_ACTIVE    = 3'd3,
        ST_FRAME_END = 3'd4
    } state_t;

    localparam logic [1:0] PAT_LINEAR  = 2'd0;
    localparam logic [1:0] PAT_HRAMP   = 2'd1;
    localparam logic [1:0] PAT_VRAMP   = 2'd2;
    localparam logic [1:0] PAT_CHECKER = 2'd3;

    function automatic logic [23:0] rgb_pack(input logic [7:0] p);
        return {p, p, p};
    endfunction

endpackage

// File: rtl/testimage_pattern_gen.sv
// Registered pixel generator.
//   clk, rst_n : clock, asynchronous active-low reset (pixel clears to 0)
//   en         : load a new pixel; when low the pixel register holds
//   pattern    : pattern code (PAT_*)
//   x_lo, y_lo : low byte of the coordinates of the pixel being loaded
//   idx        : low byte of the linear index of the pixel being loaded
//   pixel      : registered pixel, {R,G,B} zero-extended to DATA_W
module testimage_pattern_gen
    import testimage_pkg::*;
#(
    parameter int DATA_W = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [1:0]        pattern,
    input  logic [7:0]        x_lo,
    input  logic [7:0]        y_lo,
    input  logic [7:0]        idx,
    output logic [DATA_W-1:0] pixel
);

    logic [23:0] rgb_s;

    // Pixel value for the coordinates being loaded.
    always_comb begin
        rgb_s = 24'h000000;
        case (pattern)
            PAT_LINEAR:  rgb_s = rgb_pack(idx + 8'd1);
            PAT_HRAMP:   rgb_s = rgb_pack(x_lo);
            PAT_VRAMP:   rgb_s = rgb_pack(y_lo);
            PAT_CHECKER: rgb_s = (x_lo[5] ^ y_lo[5]) ? 24'hFFFFFF : 24'h000000;
            default:     rgb_s = 24'h000000;
        endcase
    end

    // Pixel register; holds while the sink stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel <= {DATA_W{1'b0}};
        end else if (en) begin
            pixel <= DATA_W'(rgb_s);
        end
    end

endmodule

// File: rtl/testimage_frame_seq.sv
// Frame-level test-image sequencer feeding the VDMA S2MM AXI4-Stream input.
// A synchronised TESTON rising edge starts a run of cfg_frames frames (0 = until
// TESTON drops). Each frame: one-cycle s2mm_fsync, C_FSYNC_GAP idle cycles, then
// hsize*vsize beats with tuser on the first beat and tlast on every line end.
//   s_axi_aclk, s_axi_aresetn     : clock, asynchronous active-low reset
//   TESTON                        : run enable level (synchronised here)
//   cfg_hsize/vsize/frames/pattern: run configuration
//   m_axis_*                      : AXI4-Stream master (all outputs registered)
//   s2mm_fsync                    : frame-start pulse
//   TESTBUSY/TESTEND/TEST_CFGERR/TEST_FRAMECNT : status
module testimage_frame_seq
    import testimage_pkg::*;
#(
    parameter int C_M_AXIS_DATA_WIDTH = 24,
    parameter int C_DIM_WIDTH         = 12,
    parameter int C_FSYNC_GAP         = 16
) (
    input  logic                           s_axi_aclk,
    input  logic                           s_axi_aresetn,
    input  logic                           TESTON,
    input  logic [C_DIM_WIDTH-1:0]         cfg_hsize,
    input  logic [C_DIM_WIDTH-1:0]         cfg_vsize,
    input  logic [7:0]                     cfg_frames,
    input  logic [1:0]                     cfg_pattern,
    output logic [C_M_AXIS_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                           m_axis_tvalid,
    input  logic                           m_axis_tready,
    output logic                           m_axis_tlast,
    output logic                           m_axis_tuser,
    output logic                           s2mm_fsync,
    output logic                           TESTBUSY,
    output logic                           TESTEND,
    output logic                           TEST_CFGERR,
    output logic [7:0]                     TEST_FRAMECNT
);

    localparam int GAP_W = $clog2(C_FSYNC_GAP + 1);
    localparam logic [GAP_W-1:0]       GAP_LAST = GAP_W'(C_FSYNC_GAP - 1);
    localparam logic [GAP_W-1:0]       GAP_ONE  = {{(GAP_W-1){1'b0}}, 1'b1};
    localparam logic [C_DIM_WIDTH-1:0] DIM_ZERO = {C_DIM_WIDTH{1'b0}};
    localparam logic [C_DIM_WIDTH-1:0] DIM_ONE  = {{(C_DIM_WIDTH-1){1'b0}}, 1'b1};

    state_t                 state_r, state_next_s;
    logic                   ton_meta_r, ton_sync_r, ton_prev_r;
    logic                   start_s, cfg_ok_s, xfer_s, eol_s, last_beat_s, load_s, more_s;
    logic [C_DIM_WIDTH-1:0] hsize_r, vsize_r, x_r, y_r, nx_s, ny_s, hsize_m1_s, vsize_m1_s;
    logic [1:0]             pattern_r;
    logic [7:0]             idx_r, nidx_s, frame_cnt_r, cnt_inc_s;
    logic [GAP_W-1:0]       gap_cnt_r;
    logic                   tvalid_r, tlast_r, tuser_r, fsync_r, busy_r, end_r, cfgerr_r;

    assign start_s     = ton_sync_r & ~ton_prev_r;
    assign cfg_ok_s    = (cfg_hsize != DIM_ZERO) && (cfg_vsize != DIM_ZERO);
    assign xfer_s      = tvalid_r & m_axis_tready;
    assign hsize_m1_s  = hsize_r - DIM_ONE;
    assign vsize_m1_s  = vsize_r - DIM_ONE;
    assign eol_s       = (x_r == hsize_m1_s);
    assign last_beat_s = eol_s && (y_r == vsize_m1_s);
    assign cnt_inc_s   = frame_cnt_r + 8'd1;
    assign more_s      = ton_sync_r && ((cfg_frames == 8'd0) || (cnt_inc_s < cfg_frames));

    // TESTON two-flop synchroniser plus previous value for edge detection.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            ton_meta_r <= 1'b0;
            ton_sync_r <= 1'b0;
            ton_prev_r <= 1'b0;
        end else begin
            ton_meta_r <= TESTON;
            ton_sync_r <= ton_meta_r;
            ton_prev_r <= ton_sync_r;
        end
    end

    // FSM state register.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next state and the coordinates of the next beat to load into the output stage.
    // A beat is loaded on the last GAP cycle (first beat) and on every accepted
    // transfer except the final one, so tvalid stays high across line ends.
    always_comb begin
        state_next_s = state_r;
        load_s       = 1'b0;
        nx_s         = x_r;
        ny_s         = y_r;
        nidx_s       = idx_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s && cfg_ok_s) begin
                    state_next_s = ST_FSYNC;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_FSYNC: state_next_s = ST_GAP;
            ST_GAP: begin
                if (gap_cnt_r == GAP_LAST) begin
                    state_next_s = ST_ACTIVE;
                    load_s       = 1'b1;
                    nx_s         = DIM_ZERO;
                    ny_s         = DIM_ZERO;
                    nidx_s       = 8'd0;
                end else begin
                    state_next_s = ST_GAP;
                end
            end
            ST_ACTIVE: begin
                if (xfer_s && last_beat_s) begin
                    state_next_s = ST_FRAME_END;
                end else if (xfer_s) begin
                    load_s = 1'b1;
                    nidx_s = idx_r + 8'd1;
                    if (eol_s) begin
                        nx_s = DIM_ZERO;
                        ny_s = y_r + DIM_ONE;
                    end else begin
                        nx_s = x_r + DIM_ONE;
                        ny_s = y_r;
                    end
                end else begin
                    state_next_s = ST_ACTIVE;
                end
            end
            ST_FRAME_END: begin
                if (more_s) begin
                    state_next_s = ST_FSYNC;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Frame configuration latch, beat counters and gap timer.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            hsize_r   <= DIM_ZERO;
            vsize_r   <= DIM_ZERO;
            pattern_r <= PAT_LINEAR;
            x_r       <= DIM_ZERO;
            y_r       <= DIM_ZERO;
            idx_r     <= 8'd0;
            gap_cnt_r <= {GAP_W{1'b0}};
        end else begin
            if (state_r == ST_FSYNC) begin
                hsize_r   <= cfg_hsize;
                vsize_r   <= cfg_vsize;
                pattern_r <= cfg_pattern;
                x_r       <= DIM_ZERO;
                y_r       <= DIM_ZERO;
                idx_r     <= 8'd0;
                gap_cnt_r <= {GAP_W{1'b0}};
            end else if (state_r == ST_GAP) begin
                gap_cnt_r <= gap_cnt_r + GAP_ONE;
            end
            if (load_s) begin
                x_r   <= nx_s;
                y_r   <= ny_s;
                idx_r <= nidx_s;
            end
        end
    end

    // Stream side-band registers; loaded together with the pixel register.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            tvalid_r <= 1'b0;
            tlast_r  <= 1'b0;
            tuser_r  <= 1'b0;
        end else if (load_s) begin
            tvalid_r <= 1'b1;
            tlast_r  <= (nx_s == hsize_m1_s);
            tuser_r  <= (nx_s == DIM_ZERO) && (ny_s == DIM_ZERO);
        end else if (state_r == ST_ACTIVE && xfer_s) begin
            tvalid_r <= 1'b0;
            tlast_r  <= 1'b0;
            tuser_r  <= 1'b0;
        end
    end

    // Status flags, frame counter and frame-sync pulse.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            fsync_r     <= 1'b0;
            busy_r      <= 1'b0;
            end_r       <= 1'b0;
            cfgerr_r    <= 1'b0;
            frame_cnt_r <= 8'd0;
        end else begin
            fsync_r <= (state_next_s == ST_FSYNC);
            busy_r  <= (state_next_s != ST_IDLE);
            if (state_r == ST_IDLE && start_s) begin
                end_r <= 1'b0;
                if (cfg_ok_s) begin
                    cfgerr_r    <= 1'b0;
                    frame_cnt_r <= 8'd0;
                end else begin
                    cfgerr_r <= 1'b1;
                end
            end else if (state_r == ST_FRAME_END) begin
                frame_cnt_r <= cnt_inc_s;
                end_r       <= ~more_s;
            end
        end
    end

    testimage_pattern_gen #(
        .DATA_W (C_M_AXIS_DATA_WIDTH)
    ) u_pattern_gen (
        .clk     (s_axi_aclk),
        .rst_n   (s_axi_aresetn),
        .en      (load_s),
        .pattern (pattern_r),
        .x_lo    (nx_s[7:0]),
        .y_lo    (ny_s[7:0]),
        .idx     (nidx_s),
        .pixel   (m_axis_tdata)
    );

    assign m_axis_tvalid = tvalid_r;
    assign m_axis_tlast  = tlast_r;
    assign m_axis_tuser  = tuser_r;
    assign s2mm_fsync    = fsync_r;
    assign TESTBUSY      = busy_r;
    assign TESTEND       = end_r;
    assign TEST_CFGERR   = cfgerr_r;
    assign TEST_FRAMECNT = frame_cnt_r;

endmodule

// File: tb/tb_testimage_frame_seq.sv
// Directed bench for testimage_frame_seq: a negedge monitor logs fsync pulses,
// accepted beats and stall stability; scenario tasks compare against
// hand-computed expectations.
module tb_testimage_frame_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        teston = 1'b0;
    logic [11:0] hsize = 12'd0;
    logic [11:0] vsize = 12'd0;
    logic [7:0]  frames = 8'd0;
    logic [1:0]  pattern = 2'd0;
    logic        tready = 1'b1;
    logic [23:0] tdata;
    logic        tvalid, tlast, tuser, fsync, busy, tend, cfgerr;
    logic [7:0]  framecnt;

    int checks = 0;
    int failures = 0;

    int cyc = 0, beat_cnt = 0, fsync_cnt = 0, stall_viol = 0, stall_seen = 0;
    int valid_cyc = 0, last_gap = 0, fsync_cyc = 0;
    logic [23:0] bd [0:4095];
    logic        bl [0:4095];
    logic        bu [0:4095];
    logic        prev_stall = 1'b0, prev_valid = 1'b0;
    logic [25:0] prev_out = 26'd0;

    testimage_frame_seq dut (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (rst_n),
        .TESTON        (teston),
        .cfg_hsize     (hsize),
        .cfg_vsize     (vsize),
        .cfg_frames    (frames),
        .cfg_pattern   (pattern),
        .m_axis_tdata  (tdata),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .m_axis_tlast  (tlast),
        .m_axis_tuser  (tuser),
        .s2mm_fsync    (fsync),
        .TESTBUSY      (busy),
        .TESTEND       (tend),
        .TEST_CFGERR   (cfgerr),
        .TEST_FRAMECNT (framecnt)
    );

    always #5 clk = ~clk;

    // Stream monitor, sampled on the falling edge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rst_n) begin
            if (fsync) begin
                fsync_cnt = fsync_cnt + 1;
                fsync_cyc = cyc;
            end
            if (tvalid) valid_cyc = valid_cyc + 1;
            if (tvalid && !prev_valid) last_gap = cyc - fsync_cyc;
            if (prev_stall && (!tvalid || {tdata, tlast, tuser} != prev_out))
                stall_viol = stall_viol + 1;
            if (tvalid && !tready) stall_seen = stall_seen + 1;
            if (tvalid && tready) begin
                if (beat_cnt < 4096) begin
                    bd[beat_cnt] = tdata;
                    bl[beat_cnt] = tlast;
                    bu[beat_cnt] = tuser;
                end
                beat_cnt = beat_cnt + 1;
            end
            prev_stall = tvalid && !tready;
            prev_out   = {tdata, tlast, tuser};
            prev_valid = tvalid;
        end else begin
            prev_stall = 1'b0;
            prev_valid = 1'b0;
        end
    end

    task automatic start_run(input logic [11:0] h, input logic [11:0] v,
                             input logic [7:0] f, input logic [1:0] pt);
        teston = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        hsize = h; vsize = v; frames = f; pattern = pt;
        teston = 1'b1;
    endtask

    // Waits for busy to rise then fall, driving tready each cycle.
    task automatic wait_done(input bit rnd, input int budget, output bit ok);
        int  n;
        bit  seen;
        n = 0;
        while (!busy && n < 20) begin
            @(posedge clk); #1;
            tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            n++;
        end
        seen = busy;
        n = 0;
        while (busy && n < budget) begin
            @(posedge clk); #1;
            tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            n++;
        end
        ok = seen && !busy;
        tready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({tdata, tvalid, tlast, tuser, fsync, busy, tend, cfgerr, framecnt} !== 39'd0) begin
            failures++;
            $display("FAIL reset_assert got %h want 0",
                     {tdata, tvalid, tlast, tuser, fsync, busy, tend, cfgerr, framecnt});
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if ({tdata, tvalid, tlast, tuser, fsync, busy, tend, cfgerr, framecnt} !== 39'd0) begin
            failures++;
            $display("FAIL reset_idle got %h want 0",
                     {tdata, tvalid, tlast, tuser, fsync, busy, tend, cfgerr, framecnt});
        end
    endtask

    // hsize=4 vsize=2 one frame, pattern 0; rnd selects random backpressure.
    task automatic test_one_frame(input bit rnd, input string tag);
        int b0, f0, s0, ss0;
        bit ok;
        logic [7:0] p;
        b0 = beat_cnt; f0 = fsync_cnt; s0 = stall_viol; ss0 = stall_seen;
        tready = 1'b1;
        start_run(12'd4, 12'd2, 8'd1, 2'd0);
        wait_done(rnd, 400, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL %s_timeout got busy=%b want 0", tag, busy); end
        checks++;
        if (fsync_cnt - f0 != 1) begin
            failures++; $display("FAIL %s_fsync got %0d want 1", tag, fsync_cnt - f0);
        end
        checks++;
        if (beat_cnt - b0 != 8) begin
            failures++; $display("FAIL %s_beats got %0d want 8", tag, beat_cnt - b0);
        end
        for (int i = 0; i < 8; i++) begin
            p = 8'(i + 1);
            checks++;
            if (bd[b0+i] !== {p, p, p} || bl[b0+i] !== (i % 4 == 3) || bu[b0+i] !== (i == 0)) begin
                failures++;
                $display("FAIL %s_beat%0d got %h/%b/%b want %h/%b/%b", tag, i, bd[b0+i],
                         bl[b0+i], bu[b0+i], {p, p, p}, (i % 4 == 3), (i == 0));
            end
        end
        checks++;
        if ({busy, tend, cfgerr, framecnt} !== {1'b0, 1'b1, 1'b0, 8'd1}) begin
            failures++;
            $display("FAIL %s_status got busy=%b end=%b err=%b cnt=%0d want 0/1/0/1",
                     tag, busy, tend, cfgerr, framecnt);
        end
        if (rnd) begin
            checks++;
            if (stall_viol != s0 || stall_seen == ss0) begin
                failures++;
                $display("FAIL %s_stall got viol=%0d stalls=%0d want viol=0 stalls>0",
                         tag, stall_viol - s0, stall_seen - ss0);
            end
        end else begin
            checks++;
            if (last_gap != 17) begin
                failures++; $display("FAIL %s_gap got %0d want 17", tag, last_gap);
            end
        end
    endtask

    task automatic test_multi_frame;
        int b0, f0;
        bit ok;
        logic [7:0] y;
        b0 = beat_cnt; f0 = fsync_cnt;
        tready = 1'b1;
        start_run(12'd2, 12'd2, 8'd3, 2'd2);
        repeat (8) @(posedge clk);
        #1 teston = 1'b0;
        repeat (4) @(posedge clk);
        #1 teston = 1'b1;
        wait_done(1'b0, 300, ok);
        checks++;
        if (!ok || fsync_cnt - f0 != 3 || beat_cnt - b0 != 12) begin
            failures++;
            $display("FAIL multi_counts got ok=%b fsync=%0d beats=%0d want 1/3/12",
                     ok, fsync_cnt - f0, beat_cnt - b0);
        end
        for (int i = 0; i < 12; i++) begin
            y = 8'((i % 4) / 2);
            checks++;
            if (bd[b0+i] !== {y, y, y} || bl[b0+i] !== (i % 2 == 1) || bu[b0+i] !== (i % 4 == 0)) begin
                failures++;
                $display("FAIL multi_beat%0d got %h/%b/%b want %h/%b/%b", i, bd[b0+i],
                         bl[b0+i], bu[b0+i], {y, y, y}, (i % 2 == 1), (i % 4 == 0));
            end
        end
        checks++;
        if ({busy, tend, framecnt} !== {1'b0, 1'b1, 8'd3}) begin
            failures++;
            $display("FAIL multi_status got busy=%b end=%b cnt=%0d want 0/1/3", busy, tend, framecnt);
        end
    endtask

    task automatic test_continuous_stop;
        int b0, f0, n;
        bit ok;
        logic [7:0] p;
        b0 = beat_cnt; f0 = fsync_cnt;
        tready = 1'b1;
        start_run(12'd4, 12'd2, 8'd0, 2'd0);
        n = 0;
        while (beat_cnt - b0 < 9 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 200) begin
            failures++; $display("FAIL cont_reach got beats=%0d want 9", beat_cnt - b0);
        end
        teston = 1'b0;
        wait_done(1'b0, 200, ok);
        checks++;
        if (!ok || fsync_cnt - f0 != 2 || beat_cnt - b0 != 16) begin
            failures++;
            $display("FAIL cont_counts got ok=%b fsync=%0d beats=%0d want 1/2/16",
                     ok, fsync_cnt - f0, beat_cnt - b0);
        end
        for (int i = 0; i < 16; i++) begin
            p = 8'((i % 8) + 1);
            checks++;
            if (bd[b0+i] !== {p, p, p} || bl[b0+i] !== (i % 4 == 3) || bu[b0+i] !== (i % 8 == 0)) begin
                failures++;
                $display("FAIL cont_beat%0d got %h/%b/%b want %h/%b/%b", i, bd[b0+i],
                         bl[b0+i], bu[b0+i], {p, p, p}, (i % 4 == 3), (i % 8 == 0));
            end
        end
        checks++;
        if ({busy, tend, framecnt} !== {1'b0, 1'b1, 8'd2}) begin
            failures++;
            $display("FAIL cont_status got busy=%b end=%b cnt=%0d want 0/1/2", busy, tend, framecnt);
        end
    endtask

    task automatic test_cfg_error;
        int b0, f0, v0;
        bit ok;
        logic [7:0] x;
        b0 = beat_cnt; f0 = fsync_cnt; v0 = valid_cyc;
        tready = 1'b1;
        start_run(12'd0, 12'd2, 8'd1, 2'd0);
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (cfgerr !== 1'b1 || busy !== 1'b0 || fsync_cnt != f0 || valid_cyc != v0) begin
            failures++;
            $display("FAIL cfgerr_set got err=%b busy=%b fsync=%0d valid=%0d want 1/0/0/0",
                     cfgerr, busy, fsync_cnt - f0, valid_cyc - v0);
        end
        start_run(12'd8, 12'd1, 8'd1, 2'd1);
        wait_done(1'b0, 200, ok);
        checks++;
        if (!ok || cfgerr !== 1'b0 || beat_cnt - b0 != 8 || framecnt !== 8'd1 || tend !== 1'b1) begin
            failures++;
            $display("FAIL cfgerr_clear got ok=%b err=%b beats=%0d cnt=%0d end=%b want 1/0/8/1/1",
                     ok, cfgerr, beat_cnt - b0, framecnt, tend);
        end
        for (int i = 0; i < 8; i++) begin
            x = 8'(i);
            checks++;
            if (bd[b0+i] !== {x, x, x} || bl[b0+i] !== (i == 7) || bu[b0+i] !== (i == 0)) begin
                failures++;
                $display("FAIL hramp_beat%0d got %h/%b/%b want %h/%b/%b", i, bd[b0+i],
                         bl[b0+i], bu[b0+i], {x, x, x}, (i == 7), (i == 0));
            end
        end
    endtask

    task automatic test_checker_reset;
        int b0, n;
        b0 = beat_cnt;
        tready = 1'b1;
        start_run(12'd64, 12'd64, 8'd1, 2'd3);
        n = 0;
        while (beat_cnt - b0 <= 2080 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        #1;
        checks++;
        if (n >= 3000) begin
            failures++; $display("FAIL chk_reach got beats=%0d want 2081", beat_cnt - b0);
        end
        checks++;
        if (bd[b0+31] !== 24'h000000 || bd[b0+32] !== 24'hFFFFFF ||
            bd[b0+2048] !== 24'hFFFFFF || bd[b0+2080] !== 24'h000000) begin
            failures++;
            $display("FAIL checker got %h %h %h %h want 000000 ffffff ffffff 000000",
                     bd[b0+31], bd[b0+32], bd[b0+2048], bd[b0+2080]);
        end
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({tdata, tvalid, tlast, tuser, fsync, busy, tend, cfgerr, framecnt} !== 39'd0) begin
            failures++;
            $display("FAIL midframe_reset got %h want 0",
                     {tdata, tvalid, tlast, tuser, fsync, busy, tend, cfgerr, framecnt});
        end
        teston = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || tvalid !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_idle got busy=%b valid=%b want 0/0", busy, tvalid);
        end
    endtask

    initial begin
        test_reset();
        test_one_frame(1'b0, "single");
        test_one_frame(1'b1, "backpressure");
        test_multi_frame();
        test_continuous_stop();
        test_cfg_error();
        test_checker_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
